alu_seq: RTL and testbench
==========================

// Module: alu_seq
//
// PURPOSE
// - Parametrised, handshaked successor to the single-cycle 16-bit ALU.
// - Width is generic, and the block adds iterative multi-bit shifts and a full Z/C/N/V flag set.
// - Sits between the operand/register path and the writeback stage.
// - The decoder presents one operation per valid/ready handshake.
// - Results are returned with a one-cycle out_valid pulse.
//
// PARAMETERS
// DATA_W    16  width of in2, out1 and the internal datapath
// OPA_W     8   width of in1; zero-extended to DATA_W before use
// SHAMT_W   5   shift-amount width; amount = in1[SHAMT_W-1:0], SHAMT_W <= OPA_W
//
// PORTS
// clk        in   1        clock; all state changes on rising edge
// rst_n      in   1        synchronous reset, active low
// in_valid   in   1        operation request
// in_ready   out  1        block can accept; high only in IDLE
// opcode     in   3        000 PASS, 001 ADD, 010 SUB, 011 INC, 100 RSH, 101 LSH, 110 RSHN, 111 LSHN
// in1        in   OPA_W    operand A, or shift amount for RSHN/LSHN
// in2        in   DATA_W   operand B (primary operand)
// out_valid  out  1        one-cycle pulse: out1/flags hold a new result
// out1       out  DATA_W   result; held until next result
// flag_z     out  1        result == 0
// flag_c     out  1        carry / borrow / last bit shifted out
// flag_n     out  1        out1[DATA_W-1]
// flag_v     out  1        signed overflow (ADD/SUB/INC only)
//
// BEHAVIOUR
// - Reset (rst_n low at a rising edge):
//   - State goes to IDLE; out1, all flags and out_valid go to 0.
//   - in_ready is 0 while rst_n is low and 1 in the first cycle after rst_n goes high.
//   - Reset during BUSY abandons the operation; no out_valid is produced for it.
// - Accept: in_valid && in_ready at a rising edge latches opcode, in1 and in2.
//   - Operands are ignored when no handshake occurs.
// - FSM states: IDLE, BUSY.
//   - IDLE to BUSY: accept of RSHN/LSHN with amount > 0.
//   - BUSY to IDLE: at the edge where the remaining count reaches 0.
//   - All other accepts stay in IDLE.
// - Latency:
//   - PASS/ADD/SUB/INC/RSH/LSH, and RSHN/LSHN with amount 0: out1 and flags update at the accept edge.
//     out_valid is high for exactly the next cycle, so back-to-back accepts give back-to-back pulses.
//   - RSHN/LSHN with amount k > 0: one bit is shifted per cycle in BUSY.
//     in_ready is low for k cycles; out_valid pulses in cycle k+1 after the accept edge.
//     out1 is not updated during BUSY.
// - Arithmetic: A = zero-extend(in1) to DATA_W. All results are truncated to DATA_W; wrap-around is silent.
//   - PASS: out1 = in2. C = V = 0.
//   - ADD: out1 = in2 + A. C = carry out of bit DATA_W-1. V = in2 sign 0 and result sign 1.
//   - SUB: out1 = in2 - A. C = 1 on borrow (in2 < A, unsigned). V = in2 sign 1 and result sign 0.
//   - INC: out1 = in2 + 1. C = (in2 == all ones). V = (in2 == 0x7F..F).
//   - RSH/LSH: logical shift by 1, zero fill. C = bit shifted out. V = 0.
//   - RSHN/LSHN: logical shift by k, zero fill. C = last bit shifted out (0 if k = 0).
//     k may exceed DATA_W: the shift runs k cycles, result is 0, C = 0. V = 0.
// - Z and N are computed from the final out1 for every opcode.
// - Flags update only together with out_valid; otherwise they hold.
// - in_valid while in_ready = 0 is not accepted; the requester must hold the request.
//
// TESTING
// 1. ADD in2=16'h00FF, in1=8'h01 -> out1=16'h0100, Z0 C0 N0 V0; out_valid one cycle after accept.
// 2. ADD in2=16'hFFFF, in1=8'h01 -> out1=16'h0000, Z1 C1 V0. ADD in2=16'h7FFF, in1=8'h01 -> out1=16'h8000, N1 V1.
// 3. SUB in2=16'h0005, in1=8'h05 -> out1=0, Z1 C0. SUB in2=16'h0003, in1=8'h05 -> out1=16'hFFFE, C1 N1.
// 4. RSHN in2=16'h8001, in1=4 -> in_ready low 4 cycles, out_valid in cycle 5, out1=16'h0800, C0.
//    LSHN in2=16'h8001, in1=1 -> out1=16'h0002, C1, latency 2.
// 5. Back-to-back INC on 16'h0000 then 16'hFFFF with in_valid held -> pulses on consecutive cycles, out1=1 then 0 (Z1 C1).
// 6. rst_n low for 1 cycle during RSHN k=10 -> no out_valid; out1/flags=0; next ADD 2+3 -> out1=5.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with Z/C/N/V flags. Single-cycle ops return on the next cycle.
// RSHN/LSHN shift one bit per cycle while BUSY.
module alu_seq #(
    parameter int DATA_W  = 16,
    parameter int OPA_W   = 8,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [OPA_W-1:0]  in1,
    input  logic [DATA_W-1:0] in2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out1,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    output logic              flag_v
);

    // state | meaning
    // IDLE  | ready for a request; single-cycle ops complete here
    // BUSY  | iterative shift in progress, sh_cnt bits remaining
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_RSH  = 3'b100;
    localparam logic [2:0] OP_LSH  = 3'b101;
    localparam logic [2:0] OP_RSHN = 3'b110;
    localparam logic [2:0] OP_LSHN = 3'b111;

    state_t              state;
    logic [DATA_W-1:0]   sh_data;
    logic [SHAMT_W-1:0]  sh_cnt;
    logic                sh_left;

    logic [DATA_W-1:0]   opa;
    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W:0]     incr;
    logic [DATA_W-1:0]   res;
    logic                res_c;
    logic                res_v;
    logic [DATA_W-1:0]   step;
    logic                step_c;
    logic                is_multi;

    assign opa      = DATA_W'(in1);
    assign shamt    = in1[SHAMT_W-1:0];
    assign sum      = {1'b0, in2} + {1'b0, opa};
    assign diff     = {1'b0, in2} - {1'b0, opa};
    assign incr     = {1'b0, in2} + (DATA_W + 1)'(1);
    assign is_multi = ((opcode == OP_RSHN) || (opcode == OP_LSHN)) && (shamt != '0);
    assign in_ready = rst_n && (state == IDLE);

    // Zero-amount RSHN/LSHN falls through to the PASS behaviour.
    always_comb begin
        res   = in2;
        res_c = 1'b0;
        res_v = 1'b0;
        case (opcode)
            OP_ADD: begin
                res   = sum[DATA_W-1:0];
                res_c = sum[DATA_W];
                res_v = ~in2[DATA_W-1] & sum[DATA_W-1];
            end
            OP_SUB: begin
                res   = diff[DATA_W-1:0];
                res_c = diff[DATA_W];
                res_v = in2[DATA_W-1] & ~diff[DATA_W-1];
            end
            OP_INC: begin
                res   = incr[DATA_W-1:0];
                res_c = incr[DATA_W];
                res_v = (in2 == {1'b0, {(DATA_W-1){1'b1}}});
            end
            OP_RSH: begin
                res   = {1'b0, in2[DATA_W-1:1]};
                res_c = in2[0];
            end
            OP_LSH: begin
                res   = {in2[DATA_W-2:0], 1'b0};
                res_c = in2[DATA_W-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        step   = {1'b0, sh_data[DATA_W-1:1]};
        step_c = sh_data[0];
        if (sh_left) begin
            step   = {sh_data[DATA_W-2:0], 1'b0};
            step_c = sh_data[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh_data   <= '0;
            sh_cnt    <= '0;
            sh_left   <= 1'b0;
            out_valid <= 1'b0;
            out1      <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_multi) begin
                            state   <= BUSY;
                            sh_data <= in2;
                            sh_cnt  <= shamt;
                            sh_left <= (opcode == OP_LSHN);
                        end else begin
                            out1      <= res;
                            flag_z    <= (res == '0);
                            flag_c    <= res_c;
                            flag_n    <= res[DATA_W-1];
                            flag_v    <= res_v;
                            out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    sh_data <= step;
                    sh_cnt  <= sh_cnt - 1'b1;
                    // Shifts beyond DATA_W keep clocking zeros, so C ends up 0.
                    if (sh_cnt == SHAMT_W'(1)) begin
                        state     <= IDLE;
                        out1      <= step;
                        flag_z    <= (step == '0);
                        flag_c    <= step_c;
                        flag_n    <= step[DATA_W-1];
                        flag_v    <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random ops checked against an arithmetic reference.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  opcode = 3'd0;
    logic [7:0]  in1 = 8'd0;
    logic [15:0] in2 = 16'd0;
    logic        out_valid;
    logic [15:0] out1;
    logic        flag_z, flag_c, flag_n, flag_v;

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] last_out;
    logic [3:0]  last_fl;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .in1(in1), .in2(in2), .out_valid(out_valid), .out1(out1),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: result, carry, overflow and latency straight from the opcode rules.
    function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic c, output logic v,
                                   output int lat);
        int k;
        logic [16:0] s;
        r = b; c = 1'b0; v = 1'b0; lat = 1;
        k = int'(a[4:0]);
        case (op)
            3'd1: begin s = {1'b0, b} + {9'd0, a}; r = s[15:0]; c = s[16]; v = !b[15] && r[15]; end
            3'd2: begin r = b - {8'd0, a}; c = (b < {8'd0, a}); v = b[15] && !r[15]; end
            3'd3: begin r = b + 16'd1; c = (b == 16'hFFFF); v = (b == 16'h7FFF); end
            3'd4: begin r = b >> 1; c = b[0]; end
            3'd5: begin r = b << 1; c = b[15]; end
            3'd6, 3'd7: begin
                if (k > 0) begin
                    lat = k + 1;
                    if (k > 16) begin r = 16'd0; c = 1'b0; end
                    else if (op == 3'd6) begin r = b >> k; c = b[k-1]; end
                    else begin r = b << k; c = b[16-k]; end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [15:0] b);
        logic [15:0] er;
        logic ec, ev;
        int elat, lat, rdy_hi;
        ref_op(op, a, b, er, ec, ev, elat);
        @(negedge clk);
        chk("ready_idle", in_ready, 1);
        in_valid = 1'b1; opcode = op; in1 = a; in2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0; rdy_hi = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
            if (in_ready) rdy_hi++;
            // Requests presented while busy must not be taken.
            in_valid = 1'($urandom); opcode = 3'($urandom); in1 = 8'($urandom); in2 = 16'($urandom);
        end
        in_valid = 1'b0;
        last_out = out1;
        last_fl = {flag_z, flag_c, flag_n, flag_v};
        chk("latency", lat, elat);
        chk("ready_low", rdy_hi, 0);
        chk("out1", out1, er);
        chk("flags_zcnv", {flag_z, flag_c, flag_n, flag_v}, {(er == 16'd0), ec, er[15], ev});
        @(negedge clk);
        chk("pulse_end", out_valid, 0);
        chk("out1_hold", out1, er);
    endtask

    initial begin
        int ov;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out1", out1, 0);
        chk("rst_flags", {flag_z, flag_c, flag_n, flag_v}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        run_op(3'd1, 8'h01, 16'h00FF);
        chk("t1_out", last_out, 16'h0100);
        chk("t1_flags", last_fl, 4'b0000);
        run_op(3'd1, 8'h01, 16'hFFFF);
        chk("t2a", {last_out, last_fl}, {16'h0000, 4'b1100});
        run_op(3'd1, 8'h01, 16'h7FFF);
        chk("t2b", {last_out, last_fl}, {16'h8000, 4'b0011});
        run_op(3'd2, 8'h05, 16'h0005);
        chk("t3a", {last_out, last_fl}, {16'h0000, 4'b1000});
        run_op(3'd2, 8'h05, 16'h0003);
        chk("t3b", {last_out, last_fl}, {16'hFFFE, 4'b0110});
        run_op(3'd6, 8'd4, 16'h8001);
        chk("t4a", {last_out, last_fl}, {16'h0800, 4'b0000});
        run_op(3'd7, 8'd1, 16'h8001);
        chk("t4b", {last_out, last_fl}, {16'h0002, 4'b0100});
        run_op(3'd7, 8'd0, 16'h1234);
        run_op(3'd6, 8'd16, 16'h8000);
        run_op(3'd7, 8'd20, 16'hFFFF);

        // Back-to-back INC with in_valid held high.
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'd3; in1 = 8'h00; in2 = 16'h0000;
        @(posedge clk);
        #1 in2 = 16'hFFFF;
        @(negedge clk);
        chk("b2b_v1", out_valid, 1);
        chk("b2b_o1", out1, 16'h0001);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_v2", out_valid, 1);
        chk("b2b_o2", {out1, flag_z, flag_c}, {16'h0000, 2'b11});
        @(negedge clk);
        chk("b2b_end", out_valid, 0);

        // Reset in the middle of a long shift.
        in_valid = 1'b1; opcode = 3'd6; in1 = 8'd10; in2 = 16'hABCD;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_ready", in_ready, 0);
        chk("mrst_state", {out_valid, out1, flag_z, flag_c, flag_n, flag_v}, 0);
        rst_n = 1'b1;
        ov = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        chk("mrst_no_pulse", ov, 0);
        run_op(3'd1, 8'd3, 16'd2);
        chk("t6_out", last_out, 16'd5);

        for (int n = 0; n < 80; n++) begin
            logic [2:0] op;
            logic [7:0] a;
            op = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            if (op >= 3'd6 && ($urandom_range(0, 3) != 0)) a = {3'($urandom), 5'($urandom_range(0, 18))};
            run_op(op, a, 16'($urandom));
            // Operands wiggling with in_valid low must not produce results.
            ov = 0;
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                opcode = 3'($urandom); in1 = 8'($urandom); in2 = 16'($urandom);
                @(negedge clk);
                if (out_valid) ov++;
            end
            chk("idle_no_pulse", ov, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
